// File: rtl/sr_lock_pkg.sv
// Shared types and defaults for the SR-flag lock controller.
package sr_lock_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  localparam int N_REQ_DEF    = 4;
  localparam int HOLD_MAX_DEF = 16;

  // Owner index width; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  // Walk the requests starting at ptr; the first hit masks all later ones.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      automatic int   idx = (int'(ptr) + k) % N_REQ;
      automatic logic hit = !any && req[idx];
      gnt[idx] = gnt[idx] | hit;
      gnt_id   = hit ? ID_W'(idx) : gnt_id;
      any      = any | hit;
    end
  end

endmodule

// File: rtl/sr_lock_ctrl.sv
// Mutual-exclusion lock over one SR flag: round-robin acquire, owner-only
// release, optional forced release after a hold limit, registered S/R pulses.
module sr_lock_ctrl
  import sr_lock_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int ID_W     = id_width(N_REQ),
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] acq_req,
  input  logic [N_REQ-1:0] rel_req,
  output logic [N_REQ-1:0] acq_gnt,
  output logic [N_REQ-1:0] rel_ack,
  output logic [N_REQ-1:0] rel_err,
  output logic             timeout,
  output logic             S,
  output logic             R,
  output logic             locked,
  output logic [ID_W-1:0]  owner
);

  lock_state_e      state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] acq_gnt_q, acq_gnt_d;
  logic [N_REQ-1:0] rel_ack_q, rel_ack_d;
  logic [N_REQ-1:0] rel_err_q, rel_err_d;
  logic             timeout_q, timeout_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             locked_q, locked_d;
  logic [ID_W-1:0]  owner_q, owner_d;

  logic [N_REQ-1:0] arb_gnt_s;
  logic [ID_W-1:0]  arb_id_s;
  logic             arb_any_s;
  logic [N_REQ-1:0] owner_oh_s;
  logic             owner_rel_s;
  logic             hold_expired_s;
  logic [ID_W-1:0]  next_ptr_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (acq_req),
    .ptr    (ptr_q),
    .gnt    (arb_gnt_s),
    .gnt_id (arb_id_s),
    .any    (arb_any_s)
  );

  // Owner decode, release qualification and hold-limit detection.
  always_comb begin
    owner_oh_s     = N_REQ'(1'b1) << owner_q;
    owner_rel_s    = |(rel_req & owner_oh_s);
    hold_expired_s = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX - 1));
    next_ptr_s     = (arb_id_s == ID_W'(N_REQ - 1)) ? '0 : arb_id_s + ID_W'(1);
  end

  // Lock FSM: pulse outputs default low and are raised only on transitions.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    acq_gnt_d = '0;
    rel_ack_d = '0;
    rel_err_d = '0;
    timeout_d = 1'b0;
    s_d       = 1'b0;
    r_d       = 1'b0;
    locked_d  = locked_q;
    owner_d   = owner_q;
    case (state_q)
      UNLOCKED: begin
        rel_err_d = rel_req;
        cnt_d     = '0;
        if (arb_any_s) begin
          state_d   = LOCKED;
          acq_gnt_d = arb_gnt_s;
          s_d       = 1'b1;
          locked_d  = 1'b1;
          owner_d   = arb_id_s;
          ptr_d     = next_ptr_s;
        end else begin
          locked_d  = 1'b0;
          owner_d   = '0;
        end
      end
      LOCKED: begin
        rel_err_d = rel_req & ~owner_oh_s;
        cnt_d     = cnt_q + CNT_W'(1);
        // An owner release in the limit cycle takes priority over the timeout.
        if (owner_rel_s) begin
          state_d   = UNLOCKED;
          rel_ack_d = owner_oh_s;
          r_d       = 1'b1;
          locked_d  = 1'b0;
          owner_d   = '0;
          cnt_d     = '0;
        end else if (hold_expired_s) begin
          state_d   = UNLOCKED;
          timeout_d = 1'b1;
          r_d       = 1'b1;
          locked_d  = 1'b0;
          owner_d   = '0;
          cnt_d     = '0;
        end else begin
          locked_d  = 1'b1;
        end
      end
      default: begin
        state_d  = UNLOCKED;
        locked_d = 1'b0;
        owner_d  = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // State and output registers; reset releases silently (no R pulse).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= UNLOCKED;
      ptr_q     <= '0;
      cnt_q     <= '0;
      acq_gnt_q <= '0;
      rel_ack_q <= '0;
      rel_err_q <= '0;
      timeout_q <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      locked_q  <= 1'b0;
      owner_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      acq_gnt_q <= acq_gnt_d;
      rel_ack_q <= rel_ack_d;
      rel_err_q <= rel_err_d;
      timeout_q <= timeout_d;
      s_q       <= s_d;
      r_q       <= r_d;
      locked_q  <= locked_d;
      owner_q   <= owner_d;
    end
  end

  assign acq_gnt = acq_gnt_q;
  assign rel_ack = rel_ack_q;
  assign rel_err = rel_err_q;
  assign timeout = timeout_q;
  assign S       = s_q;
  assign R       = r_q;
  assign locked  = locked_q;
  assign owner   = owner_q;

endmodule

// File: doc/sr_lock_ctrl.md
# sr_lock_ctrl

Lock controller that shares a single SR flag between N requesters as a mutual-exclusion semaphore. Arbitrates acquire requests round-robin, accepts release only from the current owner, and forces release after a programmable hold limit. Drives one-cycle S/R command pulses to the downstream SR flip-flop and reports lock state and owner.

## Interface
- N_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(N_REQ), owner index width
- HOLD_MAX, 16, maximum LOCKED cycles before forced release; 0 disables the timeout
- CNT_W, 8, hold counter width; must hold HOLD_MAX
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- acq_req  in  N_REQ  per-requester acquire request, level, held until granted
- rel_req  in  N_REQ  per-requester release request, level
- acq_gnt  out  N_REQ  one-hot acquire grant, one-cycle pulse
- rel_ack  out  N_REQ  one-hot release acknowledge, one-cycle pulse
- rel_err  out  N_REQ  release from a non-owner, or release while unlocked, one-cycle pulse
- timeout  out  1  forced release, one-cycle pulse
- S  out  1  set command to the SR flip-flop, one-cycle pulse
- R  out  1  reset command to the SR flip-flop, one-cycle pulse
- locked  out  1  lock held
- owner  out  ID_W  index of the current owner; 0 when unlocked

## Operation
- States: UNLOCKED, LOCKED. Reset → UNLOCKED.
- On reset, every output is 0: grants, acks, errs, timeout, S, R, locked, owner. RR pointer = 0. Hold counter = 0.
- UNLOCKED, any acq_req set:
  - Pick the first set bit at or after the pointer, wrapping at N_REQ-1 → 0.
  - Next cycle: acq_gnt[i]=1, S=1, locked=1, owner=i.
  - Pointer ← (i+1) mod N_REQ. Counter ← 0. State → LOCKED.
- UNLOCKED, rel_req[j] set: rel_err[j]=1 next cycle. No S or R pulse.
- LOCKED, rel_req[owner] set:
  - Next cycle: rel_ack[owner]=1, R=1, locked=0, owner=0.
  - State → UNLOCKED.
- LOCKED, rel_req[j] set with j≠owner: rel_err[j]=1. Lock is unaffected. Each offender gets its own error bit, several in one cycle if needed.
- LOCKED: all acq_req are ignored, including the owner's. No grant is issued and nothing is queued; requesters keep requesting.
- Hold counter increments every LOCKED cycle.
  - When HOLD_MAX≠0, counter == HOLD_MAX-1, and there is no owner release: next cycle timeout=1, R=1, locked=0, owner=0, state → UNLOCKED.
  - No rel_ack is issued on a forced release.
- Owner release and timeout in the same cycle: the release wins. rel_ack is issued and timeout stays 0.
- Invariant: S and R are never both 1. At most one acq_gnt bit is set. S=1 only on the UNLOCKED→LOCKED edge; R=1 only on LOCKED→UNLOCKED.

## Timing
- All outputs are registered.
- Latencies:
  - acq_req → acq_gnt/S: 1 cycle.
  - rel_req → rel_ack/R: 1 cycle.
- A release sampled at cycle t makes locked=0 at t+1. The earliest regrant is t+2, because the UNLOCKED state samples at t+1.
- Lock is held for exactly HOLD_MAX cycles, counting from the grant cycle, before the forced release.
- Asserting rst mid-lock clears all outputs immediately.
  - No R pulse is issued for that release.
  - The downstream SR flip-flop shares rst and clears itself.
- The grant pulse and the locked rise occur in the same cycle.

## Structure
- Package sr_lock_pkg holds:
  - the state enum (UNLOCKED, LOCKED);
  - default N_REQ and HOLD_MAX constants;
  - the helper function for the ID_W computation.
- Sub-module rr_arbiter, purely combinational:
  - inputs: req[N_REQ], ptr[ID_W];
  - outputs: one-hot gnt[N_REQ], gnt_id[ID_W], any.
- Top level holds the FSM, pointer, hold counter, output registers and error decode.

## Test plan
- Reset, then acq_req=4'b0101 → one cycle later acq_gnt=4'b0001, S=1, locked=1, owner=0. Then rel_req[0] → rel_ack=4'b0001, R=1, locked=0. Hold acq_req[2] → acq_gnt=4'b0100 two cycles after the release.
- All four requesters hold acquire, each releasing one cycle after its grant → grant order 0,1,2,3,0; never two grant bits set.
- Owner 1 holds the lock, rel_req=4'b0100 → rel_err=4'b0100; locked stays 1 and owner stays 1. rel_req in UNLOCKED → rel_err, with no R pulse.
- HOLD_MAX=16, owner never releases → timeout=1 and R=1 exactly 16 cycles after the grant cycle; locked=0. With HOLD_MAX=0, the lock is held for 100 cycles and no timeout occurs.
- Owner releases in the cycle the counter hits HOLD_MAX-1 → rel_ack=1, timeout=0.
- Assert rst asynchronously mid-lock → locked, owner, S, R and all pulses go to 0 before the next edge. Afterwards the pointer is 0: request 4'b1010 → grant to 1.
